taxi_axi_rd_arb: RTL and testbench



---
 rtl/taxi_axi_rd_arb_if.sv | 55 +++++
 rtl/taxi_axi_rd_arb.sv | 206 ++++++++++++++++++++
 tb/tb_taxi_axi_rd_arb.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_axi_rd_arb_if.sv
// AXI4 read-channel interface (AR + R) shared by requesters and the
// downstream read port. Parameters travel with the interface, so the
// arbiter can size itself from whatever is connected.
interface taxi_axi_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int ID_W      = 8,
  parameter bit ARUSER_EN = 1'b0,
  parameter int ARUSER_W  = 1,
  parameter bit RUSER_EN  = 1'b0,
  parameter int RUSER_W   = 1
) ();

  // Read address channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;

  // Read data channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport rd_slv (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

endinterface

// File: rtl/taxi_axi_rd_arb.sv
// AXI4 read arbiter: S_COUNT requesters share one read master.
// AR requests are arbitrated and registered; the grant index is prepended
// to the ID so R beats can be routed back without any extra state.
// A global counter caps the number of bursts in flight.
// Optional macro TAXI_AXI_RD_ARB_RR_EN selects round-robin arbitration;
// without it the lowest-numbered requesting port always wins.
module taxi_axi_rd_arb #(
  parameter int S_COUNT         = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axi_if.rd_slv  s_axi_rd [S_COUNT],
  taxi_axi_if.rd_mst  m_axi_rd
);

  localparam int DATA_W     = s_axi_rd[0].DATA_W;
  localparam int ADDR_W     = s_axi_rd[0].ADDR_W;
  localparam int STRB_W     = s_axi_rd[0].STRB_W;
  localparam int S_ID_W     = s_axi_rd[0].ID_W;
  localparam int M_ID_W     = m_axi_rd.ID_W;
  localparam int S_ARUSER_W = s_axi_rd[0].ARUSER_W;
  localparam int M_ARUSER_W = m_axi_rd.ARUSER_W;
  localparam int S_RUSER_W  = s_axi_rd[0].RUSER_W;
  localparam bit ARUSER_ON  = s_axi_rd[0].ARUSER_EN && m_axi_rd.ARUSER_EN;
  localparam bit RUSER_ON   = s_axi_rd[0].RUSER_EN && m_axi_rd.RUSER_EN;
  localparam int CL_S       = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Refuse to build with mismatched bus shapes
  if (m_axi_rd.DATA_W != DATA_W || m_axi_rd.STRB_W != STRB_W ||
      m_axi_rd.ADDR_W != ADDR_W) begin : g_chk_bus
    $fatal(1, "taxi_axi_rd_arb: master DATA_W/STRB_W/ADDR_W differ from requesters");
  end
  if (M_ID_W != S_ID_W + CL_S) begin : g_chk_id
    $fatal(1, "taxi_axi_rd_arb: master ID_W must be requester ID_W + CL_S");
  end

  logic [S_COUNT-1:0]    s_arvalid, s_arready, s_rready, s_rvalid;
  logic [S_ID_W-1:0]     s_arid     [S_COUNT];
  logic [ADDR_W-1:0]     s_araddr   [S_COUNT];
  logic [7:0]            s_arlen    [S_COUNT];
  logic [2:0]            s_arsize   [S_COUNT];
  logic [1:0]            s_arburst  [S_COUNT];
  logic                  s_arlock   [S_COUNT];
  logic [3:0]            s_arcache  [S_COUNT];
  logic [2:0]            s_arprot   [S_COUNT];
  logic [3:0]            s_arqos    [S_COUNT];
  logic [3:0]            s_arregion [S_COUNT];
  logic [S_ARUSER_W-1:0] s_aruser   [S_COUNT];

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      out_cnt;
  logic [M_ID_W-1:0]     arid_reg;
  logic [ADDR_W-1:0]     araddr_reg;
  logic [7:0]            arlen_reg;
  logic [2:0]            arsize_reg;
  logic [1:0]            arburst_reg;
  logic                  arlock_reg;
  logic [3:0]            arcache_reg, arqos_reg, arregion_reg;
  logic [2:0]            arprot_reg;
  logic [M_ARUSER_W-1:0] aruser_reg;

  logic                  grant_valid;
  logic [CL_S-1:0]       grant_idx;
  logic [S_COUNT-1:0]    eligible;
  logic [CL_S-1:0]       r_port;
  logic                  r_port_ok;
  logic                  m_rready;
  logic                  cnt_inc, cnt_dec;

`ifdef TAXI_AXI_RD_ARB_RR_EN
  logic [CL_S-1:0]       ptr_reg;
`endif

  // Flatten the interface array so the rest of the logic can index by variable
  for (genvar g = 0; g < S_COUNT; g++) begin : g_port
    assign s_arvalid[g]  = s_axi_rd[g].arvalid;
    assign s_arid[g]     = s_axi_rd[g].arid;
    assign s_araddr[g]   = s_axi_rd[g].araddr;
    assign s_arlen[g]    = s_axi_rd[g].arlen;
    assign s_arsize[g]   = s_axi_rd[g].arsize;
    assign s_arburst[g]  = s_axi_rd[g].arburst;
    assign s_arlock[g]   = s_axi_rd[g].arlock;
    assign s_arcache[g]  = s_axi_rd[g].arcache;
    assign s_arprot[g]   = s_axi_rd[g].arprot;
    assign s_arqos[g]    = s_axi_rd[g].arqos;
    assign s_arregion[g] = s_axi_rd[g].arregion;
    assign s_aruser[g]   = s_axi_rd[g].aruser;
    assign s_rready[g]   = s_axi_rd[g].rready;

    assign s_axi_rd[g].arready = s_arready[g];
    assign s_axi_rd[g].rid     = m_axi_rd.rid[S_ID_W-1:0];
    assign s_axi_rd[g].rdata   = m_axi_rd.rdata;
    assign s_axi_rd[g].rresp   = m_axi_rd.rresp;
    assign s_axi_rd[g].rlast   = m_axi_rd.rlast;
    assign s_axi_rd[g].ruser   = RUSER_ON ? S_RUSER_W'(m_axi_rd.ruser) : '0;
    assign s_axi_rd[g].rvalid  = s_rvalid[g];
    assign s_rvalid[g] = m_axi_rd.rvalid && r_port_ok && (r_port == CL_S'(g));
  end

  // Pick one eligible requester while idle and below the outstanding limit
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    eligible    = (state_reg == ST_IDLE && out_cnt < CNT_W'(MAX_OUTSTANDING)) ? s_arvalid : '0;
    for (int k = 0; k < S_COUNT; k++) begin
`ifdef TAXI_AXI_RD_ARB_RR_EN
      idx = (int'(ptr_reg) + k) % S_COUNT;
`else
      idx = k;
`endif
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CL_S'(idx);
      end
    end
    s_arready = grant_valid ? (S_COUNT'(1) << grant_idx) : '0;
  end

  // Route R beats by the port index carried in the top ID bits
  always_comb begin
    r_port    = m_axi_rd.rid[M_ID_W-1 -: CL_S];
    r_port_ok = int'(r_port) < S_COUNT;
    m_rready  = 1'b1;
    if (r_port_ok) begin
      m_rready = s_rready[r_port];
    end
    cnt_inc = grant_valid;
    cnt_dec = m_axi_rd.rvalid && m_rready && m_axi_rd.rlast && r_port_ok && (out_cnt != '0);
  end

  // AR state machine, field capture, outstanding counter and RR pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      out_cnt      <= '0;
      arid_reg     <= '0;
      araddr_reg   <= '0;
      arlen_reg    <= '0;
      arsize_reg   <= '0;
      arburst_reg  <= '0;
      arlock_reg   <= 1'b0;
      arcache_reg  <= '0;
      arprot_reg   <= '0;
      arqos_reg    <= '0;
      arregion_reg <= '0;
      aruser_reg   <= '0;
`ifdef TAXI_AXI_RD_ARB_RR_EN
      ptr_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            arid_reg     <= {grant_idx, s_arid[grant_idx]};
            araddr_reg   <= s_araddr[grant_idx];
            arlen_reg    <= s_arlen[grant_idx];
            arsize_reg   <= s_arsize[grant_idx];
            arburst_reg  <= s_arburst[grant_idx];
            arlock_reg   <= s_arlock[grant_idx];
            arcache_reg  <= s_arcache[grant_idx];
            arprot_reg   <= s_arprot[grant_idx];
            arqos_reg    <= s_arqos[grant_idx];
            arregion_reg <= s_arregion[grant_idx];
            aruser_reg   <= ARUSER_ON ? M_ARUSER_W'(s_aruser[grant_idx]) : '0;
            state_reg    <= ST_ISSUE;
`ifdef TAXI_AXI_RD_ARB_RR_EN
            ptr_reg      <= (int'(grant_idx) + 1 >= S_COUNT) ? '0 : grant_idx + CL_S'(1);
`endif
          end
        end
        default: begin
          if (m_axi_rd.arready) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
      if (cnt_inc && !cnt_dec) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end else if (!cnt_inc && cnt_dec) begin
        out_cnt <= out_cnt - CNT_W'(1);
      end
    end
  end

  assign m_axi_rd.arvalid  = (state_reg == ST_ISSUE);
  assign m_axi_rd.arid     = arid_reg;
  assign m_axi_rd.araddr   = araddr_reg;
  assign m_axi_rd.arlen    = arlen_reg;
  assign m_axi_rd.arsize   = arsize_reg;
  assign m_axi_rd.arburst  = arburst_reg;
  assign m_axi_rd.arlock   = arlock_reg;
  assign m_axi_rd.arcache  = arcache_reg;
  assign m_axi_rd.arprot   = arprot_reg;
  assign m_axi_rd.arqos    = arqos_reg;
  assign m_axi_rd.arregion = arregion_reg;
  assign m_axi_rd.aruser   = aruser_reg;
  assign m_axi_rd.rready   = m_rready;

endmodule

// File: tb/tb_taxi_axi_rd_arb.sv
// Directed bench for taxi_axi_rd_arb with three requesters (CL_S = 2, so
// port index 3 exercises the drop path) and MAX_OUTSTANDING = 2.
module tb_taxi_axi_rd_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  taxi_axi_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) s_if [3] ();
  taxi_axi_if #(.DATA_W(32), .ADDR_W(32), .ID_W(6)) m_if ();

  taxi_axi_rd_arb #(.S_COUNT(3), .MAX_OUTSTANDING(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_axi_rd (s_if),
    .m_axi_rd (m_if)
  );

  always #5 clk = ~clk;

  wire [2:0] s_arready_v = {s_if[2].arready, s_if[1].arready, s_if[0].arready};
  wire [2:0] s_rvalid_v  = {s_if[2].rvalid, s_if[1].rvalid, s_if[0].rvalid};

  typedef struct {
    logic [5:0] rid;
    logic       rvalid;
    logic       rlast;
    logic [2:0] rready;
    logic       exp_m_rready;
    logic [2:0] exp_rvalid;
    logic [3:0] exp_rid;
  } r_vec_t;

  r_vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rready(input logic [2:0] v);
    s_if[0].rready = v[0];
    s_if[1].rready = v[1];
    s_if[2].rready = v[2];
  endtask

  task automatic set_ar(input int p, input logic v, input logic [3:0] id,
                        input logic [31:0] addr, input logic [7:0] len);
    case (p)
      0: begin s_if[0].arvalid = v; s_if[0].arid = id; s_if[0].araddr = addr; s_if[0].arlen = len; end
      1: begin s_if[1].arvalid = v; s_if[1].arid = id; s_if[1].araddr = addr; s_if[1].arlen = len; end
      default: begin s_if[2].arvalid = v; s_if[2].arid = id; s_if[2].araddr = addr; s_if[2].arlen = len; end
    endcase
  endtask

  task automatic set_r(input logic v, input logic [5:0] id, input logic last, input logic [31:0] data);
    m_if.rvalid = v;
    m_if.rid    = id;
    m_if.rlast  = last;
    m_if.rdata  = data;
  endtask

  task automatic applyStimulus(input r_vec_t v);
    set_r(v.rvalid, v.rid, v.rlast, 32'h0);
    set_rready(v.rready);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0] exp_port [4];
    int issues;

    vecs[0] = '{6'h05, 1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 4'h5};
    vecs[1] = '{6'h1A, 1'b1, 1'b0, 3'b001, 1'b0, 3'b010, 4'hA};
    vecs[2] = '{6'h2C, 1'b1, 1'b1, 3'b100, 1'b1, 3'b100, 4'hC};
    vecs[3] = '{6'h3F, 1'b1, 1'b1, 3'b000, 1'b1, 3'b000, 4'hF};
    vecs[4] = '{6'h11, 1'b0, 1'b0, 3'b010, 1'b1, 3'b000, 4'h1};
    vecs[5] = '{6'h01, 1'b1, 1'b1, 3'b110, 1'b0, 3'b001, 4'h1};

`ifdef TAXI_AXI_RD_ARB_RR_EN
    exp_port[0] = 2'd0; exp_port[1] = 2'd1; exp_port[2] = 2'd0; exp_port[3] = 2'd1;
`else
    exp_port[0] = 2'd0; exp_port[1] = 2'd0; exp_port[2] = 2'd0; exp_port[3] = 2'd0;
`endif

    for (int p = 0; p < 3; p++) set_ar(p, 1'b0, 4'h0, 32'h0, 8'h0);
    s_if[0].arsize = '0; s_if[0].arburst = '0; s_if[0].arlock = '0; s_if[0].arcache = '0;
    s_if[0].arprot = '0; s_if[0].arqos = '0; s_if[0].arregion = '0; s_if[0].aruser = '0;
    s_if[1].arsize = '0; s_if[1].arburst = '0; s_if[1].arlock = '0; s_if[1].arcache = '0;
    s_if[1].arprot = '0; s_if[1].arqos = '0; s_if[1].arregion = '0; s_if[1].aruser = '0;
    s_if[2].arsize = '0; s_if[2].arburst = '0; s_if[2].arlock = '0; s_if[2].arcache = '0;
    s_if[2].arprot = '0; s_if[2].arqos = '0; s_if[2].arregion = '0; s_if[2].aruser = '0;
    set_rready(3'b000);
    m_if.arready = 1'b0;
    m_if.rresp   = 2'b00;
    m_if.ruser   = '0;
    set_r(1'b0, 6'h0, 1'b0, 32'h0);

    // Reset values
    tick();
    tick();
    checkOutput("reset m_arvalid", 64'(m_if.arvalid), 64'd0);
    checkOutput("reset s_arready", 64'(s_arready_v), 64'd0);
    checkOutput("reset counter", 64'(dut.out_cnt), 64'd0);
    rst = 1'b0;

    // R routing table, counter at 0 (rlast beats must not underflow it)
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d m_rready", i), 64'(m_if.rready), 64'(vecs[i].exp_m_rready));
      checkOutput($sformatf("vec%0d s_rvalid", i), 64'(s_rvalid_v), 64'(vecs[i].exp_rvalid));
      checkOutput($sformatf("vec%0d s_rid", i), 64'(s_if[0].rid), 64'(vecs[i].exp_rid));
      tick();
    end
    set_r(1'b0, 6'h0, 1'b0, 32'h0);
    set_rready(3'b000);
    checkOutput("no underflow", 64'(dut.out_cnt), 64'd0);

    // Single burst from port 1
    set_ar(1, 1'b1, 4'h3, 32'h1000, 8'd3);
    #1;
    checkOutput("single grant", 64'(s_arready_v), 64'b010);
    tick();
    set_ar(1, 1'b0, 4'h0, 32'h0, 8'h0);
    checkOutput("single m_arvalid", 64'(m_if.arvalid), 64'd1);
    checkOutput("single m_arid", 64'(m_if.arid), 64'h13);
    checkOutput("single m_araddr", 64'(m_if.araddr), 64'h1000);
    checkOutput("single m_arlen", 64'(m_if.arlen), 64'd3);
    checkOutput("single cnt up", 64'(dut.out_cnt), 64'd1);
    tick();
    checkOutput("single hold arvalid", 64'(m_if.arvalid), 64'd1);
    checkOutput("single hold arid", 64'(m_if.arid), 64'h13);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    checkOutput("single arvalid drop", 64'(m_if.arvalid), 64'd0);
    set_rready(3'b010);
    for (int b = 0; b < 4; b++) begin
      set_r(1'b1, 6'h13, (b == 3), 32'h100 + 32'(b));
      #1;
      checkOutput($sformatf("beat%0d rvalid", b), 64'(s_rvalid_v), 64'b010);
      checkOutput($sformatf("beat%0d rid", b), 64'(s_if[1].rid), 64'h3);
      checkOutput($sformatf("beat%0d rdata", b), 64'(s_if[1].rdata), 64'h100 + 64'(b));
      checkOutput($sformatf("beat%0d rlast", b), 64'(s_if[1].rlast), 64'(b == 3));
      tick();
    end
    set_r(1'b0, 6'h0, 1'b0, 32'h0);
    checkOutput("single cnt down", 64'(dut.out_cnt), 64'd0);

    // Ports 0 and 1 contend; R stream keeps completing bursts
    set_rready(3'b111);
    set_r(1'b1, 6'h00, 1'b1, 32'h0);
    m_if.arready = 1'b1;
    set_ar(0, 1'b1, 4'h1, 32'h40, 8'd0);
    set_ar(1, 1'b1, 4'h2, 32'h80, 8'd0);
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (m_if.arvalid) begin
        if (issues < 4) checkOutput($sformatf("arb issue%0d port", issues), 64'(m_if.arid[5:4]), 64'(exp_port[issues]));
        issues++;
      end
    end
    set_ar(0, 1'b0, 4'h0, 32'h0, 8'h0);
    set_ar(1, 1'b0, 4'h0, 32'h0, 8'h0);
    set_r(1'b0, 6'h0, 1'b0, 32'h0);
    set_rready(3'b000);
    checkOutput("arb issue count", 64'(issues), 64'd4);
    checkOutput("arb cnt end", 64'(dut.out_cnt), 64'd0);

    // Outstanding limit of two bursts
    set_ar(0, 1'b1, 4'h4, 32'h200, 8'd1);
    tick();
    tick();
    tick();
    tick();
    checkOutput("limit cnt", 64'(dut.out_cnt), 64'd2);
    checkOutput("limit held off", 64'(s_arready_v), 64'd0);
    tick();
    checkOutput("limit still held", 64'(s_arready_v), 64'd0);
    checkOutput("limit no issue", 64'(m_if.arvalid), 64'd0);
    set_rready(3'b001);
    set_r(1'b1, 6'h04, 1'b1, 32'h0);
    tick();
    set_r(1'b0, 6'h0, 1'b0, 32'h0);
    #1;
    checkOutput("limit third accepted", 64'(s_arready_v), 64'b001);
    checkOutput("limit cnt after rlast", 64'(dut.out_cnt), 64'd1);
    tick();
    set_ar(0, 1'b0, 4'h0, 32'h0, 8'h0);
    checkOutput("limit third issue", 64'(m_if.arvalid), 64'd1);
    checkOutput("limit cnt full", 64'(dut.out_cnt), 64'd2);

    // Same-cycle increment and decrement at counter 1
    set_r(1'b1, 6'h04, 1'b1, 32'h0);
    tick();
    checkOutput("same pre cnt", 64'(dut.out_cnt), 64'd1);
    set_ar(1, 1'b1, 4'h9, 32'h300, 8'd0);
    #1;
    checkOutput("same grant", 64'(s_arready_v), 64'b010);
    tick();
    set_ar(1, 1'b0, 4'h0, 32'h0, 8'h0);
    set_r(1'b0, 6'h0, 1'b0, 32'h0);
    checkOutput("same cnt", 64'(dut.out_cnt), 64'd1);
    checkOutput("same m_arid", 64'(m_if.arid), 64'h19);
    tick();
    m_if.arready = 1'b0;
    set_r(1'b1, 6'h19, 1'b1, 32'h0);
    set_rready(3'b010);
    tick();
    set_r(1'b0, 6'h0, 1'b0, 32'h0);
    checkOutput("drain cnt", 64'(dut.out_cnt), 64'd0);

    // R backpressure from port 0
    set_rready(3'b000);
    set_r(1'b1, 6'h05, 1'b0, 32'hCAFE);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("bp%0d m_rready", c), 64'(m_if.rready), 64'd0);
      checkOutput($sformatf("bp%0d s0 rdata", c), 64'(s_if[0].rdata), 64'hCAFE);
      checkOutput($sformatf("bp%0d s0 rvalid", c), 64'(s_rvalid_v), 64'b001);
      tick();
    end
    set_rready(3'b001);
    #1;
    checkOutput("bp release", 64'(m_if.rready), 64'd1);
    tick();
    set_r(1'b0, 6'h0, 1'b0, 32'h0);
    set_rready(3'b000);

    // Reset while ISSUE is stalled
    set_ar(1, 1'b1, 4'h2, 32'h2000, 8'd0);
    tick();
    set_ar(1, 1'b0, 4'h0, 32'h0, 8'h0);
    checkOutput("rst pre arvalid", 64'(m_if.arvalid), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rst arvalid", 64'(m_if.arvalid), 64'd0);
    checkOutput("rst cnt", 64'(dut.out_cnt), 64'd0);
    checkOutput("rst state", 64'(dut.state_reg), 64'd0);
    rst = 1'b0;
    set_ar(1, 1'b1, 4'h7, 32'h3000, 8'd1);
    #1;
    checkOutput("post rst grant", 64'(s_arready_v), 64'b010);
    tick();
    set_ar(1, 1'b0, 4'h0, 32'h0, 8'h0);
    checkOutput("post rst arid", 64'(m_if.arid), 64'h17);
    checkOutput("post rst araddr", 64'(m_if.araddr), 64'h3000);
    checkOutput("post rst cnt", 64'(dut.out_cnt), 64'd1);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    checkOutput("post rst done", 64'(m_if.arvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
